// File: rtl/exec_seq_pkg.sv
// Shared definitions for the exec_sequencer fetch/decode/execute controller:
// control opcodes, FSM states, instruction field positions and flag indices.
package exec_seq_pkg;

  localparam logic [4:0] OP_JMP = 5'b11100;
  localparam logic [4:0] OP_JZ  = 5'b11101;
  localparam logic [4:0] OP_JC  = 5'b11110;
  localparam logic [4:0] OP_HLT = 5'b11111;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    EXEC,
    MEM,
    WB,
    HALT
  } state_t;

  localparam int unsigned OPC_MSB   = 15;
  localparam int unsigned OPC_LSB   = 11;
  localparam int unsigned AM_BIT    = 10;
  localparam int unsigned RD_MSB    = 9;
  localparam int unsigned RD_LSB    = 7;
  localparam int unsigned RS1_MSB   = 6;
  localparam int unsigned RS1_LSB   = 4;
  localparam int unsigned RS2_MSB   = 3;
  localparam int unsigned RS2_LSB   = 1;
  localparam int unsigned SRA_MSB   = 3;
  localparam int unsigned SRA_LSB   = 1;
  localparam int unsigned MADDR_MSB = 3;
  localparam int unsigned MADDR_LSB = 0;
  localparam int unsigned TGT_MSB   = 5;
  localparam int unsigned TGT_LSB   = 0;

  // flags_q packing: {zero, carry, ac, parity}
  localparam int unsigned FLAG_ZERO   = 3;
  localparam int unsigned FLAG_CARRY  = 2;
  localparam int unsigned FLAG_AC     = 1;
  localparam int unsigned FLAG_PARITY = 0;

endpackage

// File: rtl/exec_seq_decode.sv
// Combinational instruction decoder: splits a 16-bit word into control fields
// and classifies it as branch / halt, resolving branch direction from flags.
module exec_seq_decode
  import exec_seq_pkg::*;
(
  input  logic [15:0] ir,
  input  logic        flag_zero,
  input  logic        flag_carry,
  output logic [4:0]  opcode,
  output logic        am,
  output logic [2:0]  rd,
  output logic [2:0]  rs1,
  output logic [2:0]  rs2,
  output logic [2:0]  s_r_amount,
  output logic [3:0]  mem_addr,
  output logic [5:0]  target,
  output logic        is_branch,
  output logic        is_halt,
  output logic        is_taken
);

  assign opcode     = ir[OPC_MSB:OPC_LSB];
  assign am         = ir[AM_BIT];
  assign rd         = ir[RD_MSB:RD_LSB];
  assign rs1        = ir[RS1_MSB:RS1_LSB];
  assign rs2        = ir[RS2_MSB:RS2_LSB];
  assign s_r_amount = ir[SRA_MSB:SRA_LSB];
  assign mem_addr   = ir[MADDR_MSB:MADDR_LSB];
  assign target     = ir[TGT_MSB:TGT_LSB];

  always_comb begin
    is_branch = 1'b0;
    is_halt   = 1'b0;
    is_taken  = 1'b0;
    case (opcode)
      OP_JMP: begin is_branch = 1'b1; is_taken = 1'b1;       end
      OP_JZ:  begin is_branch = 1'b1; is_taken = flag_zero;  end
      OP_JC:  begin is_branch = 1'b1; is_taken = flag_carry; end
      OP_HLT: is_halt = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/exec_sequencer.sv
// Multi-cycle fetch/decode/execute controller driving the executestage datapath.
// Optional EXEC_SEQ_PERF_EN adds a 16-bit retired-instruction counter port.
module exec_sequencer
  import exec_seq_pkg::*;
#(
  parameter int unsigned IMEM_AW  = 6,
  parameter int unsigned RESET_PC = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  output logic               imem_en,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [15:0]        imem_rdata,
  output logic               exe_enable,
  output logic [4:0]         opcode,
  output logic               am,
  output logic [2:0]         rd,
  output logic [2:0]         rs1,
  output logic [2:0]         rs2,
  output logic [2:0]         s_r_amount,
  output logic [3:0]         mem_addr,
  output logic [IMEM_AW-1:0] instr_mem_addr,
  input  logic               zero_flag,
  input  logic               carry_flag,
  input  logic               ac_flag,
  input  logic               parity_flag,
  output logic [3:0]         flags_q,
  output logic               halted,
  output logic               retire
`ifdef EXEC_SEQ_PERF_EN
  ,
  output logic [15:0]        perf_retired
`endif
);

  state_t state, state_next;

  logic [IMEM_AW-1:0] pc;
  logic [IMEM_AW-1:0] pc_inc;
  logic [15:0]        ir;
  logic [15:0]        dec_word;

  logic [4:0] dec_opcode;
  logic       dec_am;
  logic [2:0] dec_rd, dec_rs1, dec_rs2, dec_sra;
  logic [3:0] dec_mem_addr;
  logic [5:0] dec_target;
  logic       dec_is_branch, dec_is_halt, dec_is_taken;

  // In DECODE the word is still on imem_rdata; afterwards it lives in ir.
  assign dec_word  = (state == DECODE) ? imem_rdata : ir;
  assign pc_inc    = pc + IMEM_AW'(1);
  assign imem_addr = pc;

  exec_seq_decode u_decode (
    .ir         (dec_word),
    .flag_zero  (flags_q[FLAG_ZERO]),
    .flag_carry (flags_q[FLAG_CARRY]),
    .opcode     (dec_opcode),
    .am         (dec_am),
    .rd         (dec_rd),
    .rs1        (dec_rs1),
    .rs2        (dec_rs2),
    .s_r_amount (dec_sra),
    .mem_addr   (dec_mem_addr),
    .target     (dec_target),
    .is_branch  (dec_is_branch),
    .is_halt    (dec_is_halt),
    .is_taken   (dec_is_taken)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = FETCH;
      FETCH:   state_next = DECODE;
      DECODE:  state_next = dec_is_halt ? HALT : EXEC;
      EXEC:    begin
        if (dec_is_branch) state_next = FETCH;
        else if (dec_am)   state_next = MEM;
        else               state_next = WB;
      end
      MEM:     state_next = WB;
      WB:      state_next = FETCH;
      HALT:    state_next = HALT;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    imem_en    = (state == FETCH);
    exe_enable = ((state == EXEC) && !dec_is_branch) || (state == MEM);
    retire     = (state == WB) || ((state == EXEC) && dec_is_branch);
    halted     = (state == HALT);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc             <= IMEM_AW'(RESET_PC);
      ir             <= '0;
      opcode         <= '0;
      am             <= 1'b0;
      rd             <= '0;
      rs1            <= '0;
      rs2            <= '0;
      s_r_amount     <= '0;
      mem_addr       <= '0;
      instr_mem_addr <= '0;
      flags_q        <= '0;
    end else begin
      if (state == DECODE) begin
        ir <= imem_rdata;
        if (!dec_is_halt) begin
          opcode         <= dec_opcode;
          am             <= dec_am;
          rd             <= dec_rd;
          rs1            <= dec_rs1;
          rs2            <= dec_rs2;
          s_r_amount     <= dec_sra;
          mem_addr       <= dec_mem_addr;
          instr_mem_addr <= pc;
        end
      end
      if ((state == EXEC) && dec_is_branch)
        pc <= dec_is_taken ? IMEM_AW'(dec_target) : pc_inc;
      if (state == WB) begin
        flags_q <= {zero_flag, carry_flag, ac_flag, parity_flag};
        pc      <= pc_inc;
      end
    end
  end

`ifdef EXEC_SEQ_PERF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       perf_retired <= '0;
    else if (retire) perf_retired <= perf_retired + 16'd1;
  end
`endif

endmodule
